// File: rtl/mrr_loopback_pop_requester.sv
// Loopback pop requester: on a decoded packet, pops the matching loopback message
// and presents it to the transmitter. Optional pop timeout: MRR_LOOPBACK_POP_TIMEOUT_EN.
module mrr_loopback_pop_requester #(
  parameter int CHIP_ID_LEN          = 20,
  parameter int LOOPBACK_MESSAGE_LEN = 64,
  parameter int POP_TIMEOUT_CYCLES   = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            decode_valid,
  input  logic [CHIP_ID_LEN-1:0]          decode_chip_id,
  output logic                            busy,
  output logic [CHIP_ID_LEN-1:0]          pop_chip_id,
  output logic                            pop_request,
  input  logic                            pop_ack,
  input  logic [LOOPBACK_MESSAGE_LEN-1:0] pop_message,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  output logic [LOOPBACK_MESSAGE_LEN-1:0] tx_message,
  output logic                            timeout_error,
  output logic [7:0]                      drop_count
);

  typedef enum logic [1:0] {IDLE, REQUEST, PRESENT} state_t;

  state_t                          state, state_nxt;
  logic                            pop_request_nxt;
  logic [CHIP_ID_LEN-1:0]          pop_chip_id_nxt;
  logic                            tx_valid_nxt;
  logic [LOOPBACK_MESSAGE_LEN-1:0] tx_message_nxt;
  logic [7:0]                      drop_count_nxt;

`ifdef MRR_LOOPBACK_POP_TIMEOUT_EN
  // Timeout fires on the edge where the counter reaches POP_TIMEOUT_CYCLES-1.
  localparam logic [15:0] TIMEOUT_LAST = 16'(POP_TIMEOUT_CYCLES - 2);
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic        timeout_q, timeout_nxt;
  assign timeout_error = timeout_q;
`else
  assign timeout_error = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_nxt       = state;
    pop_request_nxt = pop_request;
    pop_chip_id_nxt = pop_chip_id;
    tx_valid_nxt    = tx_valid;
    tx_message_nxt  = tx_message;
    drop_count_nxt  = drop_count;
`ifdef MRR_LOOPBACK_POP_TIMEOUT_EN
    wait_cnt_nxt    = wait_cnt;
    timeout_nxt     = 1'b0;
`endif

    if (decode_valid && (state != IDLE) && (drop_count != 8'hFF))
      drop_count_nxt = drop_count + 8'd1;

    unique case (state)
      IDLE: begin
        if (decode_valid) begin
          state_nxt       = REQUEST;
          pop_request_nxt = 1'b1;
          pop_chip_id_nxt = decode_chip_id;
`ifdef MRR_LOOPBACK_POP_TIMEOUT_EN
          wait_cnt_nxt    = '0;
`endif
        end
      end
      REQUEST: begin
        if (pop_ack) begin
          pop_request_nxt = 1'b0;
          tx_message_nxt  = pop_message;
          // An all-zero message means the queue had nothing for this chip.
          if (pop_message != '0) begin
            state_nxt    = PRESENT;
            tx_valid_nxt = 1'b1;
          end else begin
            state_nxt    = IDLE;
          end
        end
`ifdef MRR_LOOPBACK_POP_TIMEOUT_EN
        else if (wait_cnt == TIMEOUT_LAST) begin
          wait_cnt_nxt    = wait_cnt + 16'd1;
          pop_request_nxt = 1'b0;
          timeout_nxt     = 1'b1;
          state_nxt       = IDLE;
        end else begin
          wait_cnt_nxt    = wait_cnt + 16'd1;
        end
`endif
      end
      PRESENT: begin
        if (tx_ready) begin
          tx_valid_nxt = 1'b0;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state       <= IDLE;
      pop_request <= 1'b0;
      pop_chip_id <= '0;
      tx_valid    <= 1'b0;
      tx_message  <= '0;
      drop_count  <= '0;
`ifdef MRR_LOOPBACK_POP_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      pop_request <= pop_request_nxt;
      pop_chip_id <= pop_chip_id_nxt;
      tx_valid    <= tx_valid_nxt;
      tx_message  <= tx_message_nxt;
      drop_count  <= drop_count_nxt;
`ifdef MRR_LOOPBACK_POP_TIMEOUT_EN
      wait_cnt    <= wait_cnt_nxt;
      timeout_q   <= timeout_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mrr_loopback_pop_requester.sv
// Directed self-checking bench for mrr_loopback_pop_requester; the timeout scenario
// follows the MRR_LOOPBACK_POP_TIMEOUT_EN build setting.
module tb_mrr_loopback_pop_requester;

  localparam int CW = 20;
  localparam int MW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          decode_valid;
  logic [CW-1:0] decode_chip_id;
  logic          busy;
  logic [CW-1:0] pop_chip_id;
  logic          pop_request;
  logic          pop_ack;
  logic [MW-1:0] pop_message;
  logic          tx_valid;
  logic          tx_ready;
  logic [MW-1:0] tx_message;
  logic          timeout_error;
  logic [7:0]    drop_count;

  int checks   = 0;
  int failures = 0;

  mrr_loopback_pop_requester #(
    .CHIP_ID_LEN(CW), .LOOPBACK_MESSAGE_LEN(MW), .POP_TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .decode_valid(decode_valid), .decode_chip_id(decode_chip_id),
    .busy(busy), .pop_chip_id(pop_chip_id), .pop_request(pop_request),
    .pop_ack(pop_ack), .pop_message(pop_message),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_message(tx_message),
    .timeout_error(timeout_error), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; decode_valid = 1'b0; decode_chip_id = '0;
    pop_ack = 1'b0; pop_message = '0; tx_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, pop_request, tx_valid, timeout_error, drop_count, pop_chip_id, tx_message} !== '0) begin
      failures++;
      $display("FAIL reset_state got busy=%0b req=%0b txv=%0b to=%0b drop=%0d id=%h msg=%h exp all zero",
               busy, pop_request, tx_valid, timeout_error, drop_count, pop_chip_id, tx_message);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    decode_valid = 1'b1; decode_chip_id = 20'h12345;
    tick();
    decode_valid = 1'b0; decode_chip_id = '0;
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (pop_request !== 1'b1 || pop_chip_id !== 20'h12345 || busy !== 1'b1 || tx_valid !== 1'b0) begin
        failures++;
        $display("FAIL basic_request cyc%0d got req=%0b id=%h busy=%0b txv=%0b exp req=1 id=12345 busy=1 txv=0",
                 c, pop_request, pop_chip_id, busy, tx_valid);
      end
      if (c < 5) tick();
    end
    pop_ack = 1'b1; pop_message = 64'hA5A5;
    tick();
    pop_ack = 1'b0; pop_message = 64'hFFFF_0000_FFFF_0000;
    checks++;
    if (pop_request !== 1'b0 || tx_valid !== 1'b1 || tx_message !== 64'hA5A5 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_present got req=%0b txv=%0b msg=%h busy=%0b exp req=0 txv=1 msg=a5a5 busy=1",
               pop_request, tx_valid, tx_message, busy);
    end
  endtask

  task automatic test_hold();
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin pop_ack = 1'b1; pop_message = 64'hDEAD; end
      tick();
      pop_ack = 1'b0;
      checks++;
      if (tx_valid !== 1'b1 || tx_message !== 64'hA5A5 || pop_request !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable i=%0d got txv=%0b msg=%h req=%0b exp txv=1 msg=a5a5 req=0",
                 i, tx_valid, tx_message, pop_request);
      end
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_message !== 64'hA5A5) begin
      failures++;
      $display("FAIL hold_release got txv=%0b busy=%0b msg=%h exp txv=0 busy=0 msg=a5a5",
               tx_valid, busy, tx_message);
    end
    pop_ack = 1'b1; pop_message = 64'h1234;
    tick();
    pop_ack = 1'b0;
    checks++;
    if (busy !== 1'b0 || pop_request !== 1'b0 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_ack_ignored got busy=%0b req=%0b txv=%0b exp 0 0 0", busy, pop_request, tx_valid);
    end
  endtask

  task automatic test_null_message();
    decode_valid = 1'b1; decode_chip_id = 20'hABCDE;
    tick();
    decode_valid = 1'b0;
    checks++;
    if (pop_request !== 1'b1 || pop_chip_id !== 20'hABCDE) begin
      failures++;
      $display("FAIL null_request got req=%0b id=%h exp req=1 id=abcde", pop_request, pop_chip_id);
    end
    pop_ack = 1'b1; pop_message = '0;
    tick();
    pop_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy !== 1'b0 || tx_valid !== 1'b0 || pop_request !== 1'b0) begin
        failures++;
        $display("FAIL null_idle i=%0d got busy=%0b txv=%0b req=%0b exp 0 0 0", i, busy, tx_valid, pop_request);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    decode_valid = 1'b1; decode_chip_id = 20'h00001;
    tick();
    decode_valid = 1'b0;
    pop_ack = 1'b1; pop_message = 64'h1111;
    tick();
    pop_ack = 1'b0;
    tx_ready = 1'b1; decode_valid = 1'b1; decode_chip_id = 20'h00002;
    tick();
    tx_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || drop_count !== 8'd1 || pop_request !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drop got busy=%0b drop=%0d req=%0b exp busy=0 drop=1 req=0", busy, drop_count, pop_request);
    end
    decode_chip_id = 20'h00003;
    tick();
    decode_valid = 1'b0;
    checks++;
    if (pop_request !== 1'b1 || pop_chip_id !== 20'h00003) begin
      failures++;
      $display("FAIL b2b_accept got req=%0b id=%h exp req=1 id=00003", pop_request, pop_chip_id);
    end
    pop_ack = 1'b1; pop_message = 64'h3333;
    tick();
    pop_ack = 1'b0;
    checks++;
    if (tx_valid !== 1'b1 || tx_message !== 64'h3333) begin
      failures++;
      $display("FAIL b2b_present got txv=%0b msg=%h exp txv=1 msg=3333", tx_valid, tx_message);
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    decode_valid = 1'b1; decode_chip_id = 20'h00005;
    tick();
    decode_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, pop_request, tx_valid, timeout_error, drop_count, pop_chip_id, tx_message} !== '0) begin
      failures++;
      $display("FAIL reset_mid_request got busy=%0b req=%0b txv=%0b drop=%0d id=%h msg=%h exp all zero",
               busy, pop_request, tx_valid, drop_count, pop_chip_id, tx_message);
    end
    pop_ack = 1'b1; pop_message = 64'hBEEF;
    tick();
    pop_ack = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_stale_ack got txv=%0b busy=%0b exp 0 0", tx_valid, busy);
    end
    decode_valid = 1'b1; decode_chip_id = 20'h00007;
    tick();
    decode_valid = 1'b0;
    pop_ack = 1'b1; pop_message = 64'h77;
    tick();
    pop_ack = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, pop_request, tx_valid, timeout_error, drop_count, pop_chip_id, tx_message} !== '0) begin
      failures++;
      $display("FAIL reset_mid_present got busy=%0b req=%0b txv=%0b id=%h msg=%h exp all zero",
               busy, pop_request, tx_valid, pop_chip_id, tx_message);
    end
  endtask

  task automatic test_timeout();
    decode_valid = 1'b1; decode_chip_id = 20'h00009;
    tick();
    decode_valid = 1'b0;
`ifdef MRR_LOOPBACK_POP_TIMEOUT_EN
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if (pop_request !== 1'b1 || timeout_error !== 1'b0) begin
        failures++;
        $display("FAIL timeout_wait cyc%0d got req=%0b to=%0b exp req=1 to=0", c, pop_request, timeout_error);
      end
      tick();
    end
    checks++;
    if (timeout_error !== 1'b1 || pop_request !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_fire got to=%0b req=%0b busy=%0b exp to=1 req=0 busy=0", timeout_error, pop_request, busy);
    end
    pop_ack = 1'b1; pop_message = 64'h55;
    tick();
    pop_ack = 1'b0;
    checks++;
    if (timeout_error !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_stale_ack got to=%0b txv=%0b busy=%0b exp 0 0 0", timeout_error, tx_valid, busy);
    end
`else
    for (int c = 1; c <= 20; c++) begin
      checks++;
      if (pop_request !== 1'b1 || timeout_error !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL no_timeout cyc%0d got req=%0b to=%0b busy=%0b exp req=1 to=0 busy=1",
                 c, pop_request, timeout_error, busy);
      end
      tick();
    end
    pop_ack = 1'b1; pop_message = '0;
    tick();
    pop_ack = 1'b0;
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL no_timeout_exit got busy=%0b txv=%0b exp 0 0", busy, tx_valid);
    end
`endif
  endtask

  task automatic test_drop_saturate();
    decode_valid = 1'b1; decode_chip_id = 20'hF0F0F;
    tick();
    decode_chip_id = 20'h0AAAA;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 254 || i == 255 || i == 300) begin
        checks++;
        if (drop_count !== ((i > 255) ? 8'd255 : 8'(i))) begin
          failures++;
          $display("FAIL drop_count after %0d pulses got=%0d exp=%0d", i, drop_count, (i > 255) ? 255 : i);
        end
      end
    end
    decode_valid = 1'b0;
    checks++;
    if (pop_chip_id !== 20'hF0F0F || pop_request !== 1'b1) begin
      failures++;
      $display("FAIL drop_id_stable got id=%h req=%0b exp id=f0f0f req=1", pop_chip_id, pop_request);
    end
    pop_ack = 1'b1; pop_message = '0;
    tick();
    pop_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_null_message();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_drop_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
